// File: rtl/sram_arbiter.sv
// Two-port (CPU / DMA) arbiter for an asynchronous SRAM.
// Each granted access runs SETUP -> ACTIVE (ACCESS_CYCLES) -> RECOVER -> IDLE.
// Simultaneous requests are resolved round-robin.
// Strobes, bus outputs and acks are all registered, so the SRAM pins do not glitch.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        sram_csb,
    output logic        sram_oeb,
    output logic        sram_web,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    input  logic [7:0]  sram_din
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_RECOVER
    } state_t;

    localparam logic       GNT_CPU  = 1'b0;
    localparam logic       GNT_DMA  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        csb_q, csb_d;
    logic        oeb_q, oeb_d;
    logic        web_q, web_d;
    logic        doe_q, doe_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        start;
    logic        pick;

    // Arbitration: a lone request wins outright, a tie goes to the port not granted last.
    always_comb begin
        start = 1'b0;
        pick  = last_q;
        if (cpu_req && dma_req) begin
            start = 1'b1;
            pick  = ~last_q;
        end else if (cpu_req) begin
            start = 1'b1;
            pick  = GNT_CPU;
        end else if (dma_req) begin
            start = 1'b1;
            pick  = GNT_DMA;
        end
    end

    // Next-state logic, request latching, read capture and next values of the registered pins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    gnt_d   = pick;
                    last_d  = pick;
                    we_d    = (pick == GNT_DMA) ? dma_we    : cpu_we;
                    addr_d  = (pick == GNT_DMA) ? dma_addr  : cpu_addr;
                    wdata_d = (pick == GNT_DMA) ? dma_wdata : cpu_wdata;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACTIVE;
                cnt_d   = CNT_LOAD;
            end
            ST_ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECOVER;
                    // Read data is sampled at the edge closing the strobe window.
                    if (!we_q) begin
                        if (gnt_q == GNT_DMA) begin
                            dma_rdata_d = sram_din;
                        end else begin
                            cpu_rdata_d = sram_din;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin values decoded from the state being entered, so they change with the state register.
        csb_d     = 1'b1;
        oeb_d     = 1'b1;
        web_d     = 1'b1;
        doe_d     = 1'b0;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        unique case (state_d)
            ST_SETUP: begin
                csb_d = 1'b0;
                oeb_d = we_d;
                doe_d = we_d;
            end
            ST_ACTIVE: begin
                csb_d = 1'b0;
                oeb_d = we_d;
                web_d = ~we_d;
                doe_d = we_d;
            end
            ST_RECOVER: begin
                // Keep driving the bus one more cycle after a write for data hold.
                doe_d     = we_d;
                cpu_ack_d = (gnt_d == GNT_CPU);
                dma_ack_d = (gnt_d == GNT_DMA);
            end
            default: begin
                csb_d = 1'b1;
            end
        endcase
    end

    // State, latched request and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            gnt_q       <= GNT_CPU;
            last_q      <= GNT_DMA;
            we_q        <= 1'b0;
            addr_q      <= 19'd0;
            wdata_q     <= 8'd0;
            csb_q       <= 1'b1;
            oeb_q       <= 1'b1;
            web_q       <= 1'b1;
            doe_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            csb_q       <= csb_d;
            oeb_q       <= oeb_d;
            web_q       <= web_d;
            doe_q       <= doe_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign sram_csb  = csb_q;
    assign sram_oeb  = oeb_q;
    assign sram_web  = web_q;
    assign sram_doe  = doe_q;
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule
